// File: rtl/pipe_addn.sv
// -----------------------------------------------------------------------------
// pipe_addn -- streaming sliding-window float32 summer.
//
// Produces the sum of the last N = 2**LOG2N accepted samples. Once the window is
// full, every accepted sample yields one result. The sum is computed by a
// balanced pairwise tree of float_add instances fed directly from the tap chain.
//
// Optional feature (compile-time macro PIPE_ADDN_MEAN_EN): the output register
// loads sum/N, done by an exponent adjust with flush-to-zero on underflow.
// Without the macro the raw window sum is output.
//
// Ports (pipe_addn):
//   clock     in   1   rising-edge clock
//   aclr_n    in   1   asynchronous active-low reset
//   clk_en    in   1   global stall; 0 freezes every register and adder stage
//   in_valid  in   1   qualifies 'in'; accepted when clk_en & in_valid
//   in        in  32   float32 sample
//   flush     in   1   synchronous window clear (takes priority over accept)
//   result    out 32   float32 window sum (or mean)
//   out_valid out  1   one pulse per result
//   full      out  1   window holds N samples
//
// Ports (float_add): clock, aclr (active high), clk_en, dataa, datab, result.
// Latency LAT clock-enabled cycles; round-to-nearest-even, denormals treated
// as zero, NaN results canonical (0x7FC00000).
// -----------------------------------------------------------------------------

module float_add #(
  parameter int LAT = 7
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [26:0]       mys;
    logic              sticky;
    logic [27:0]       s;
    logic signed [9:0] e;
    logic [24:0]       m;
    logic              rnd;
    logic              done;
    logic [31:0]       r;
    begin
      // x is the operand of larger magnitude; it also sets the result sign
      if (a[30:0] >= b[30:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
      my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
      d  = x[30:23] - y[30:23];
      // Align the smaller operand, folding shifted-out bits into a sticky bit
      if (d >= 8'd27) begin
        mys    = 27'd0;
        sticky = |my;
      end else begin
        mys    = my >> d;
        sticky = |(my & ((27'd1 << d) - 27'd1));
      end
      mys[0] = mys[0] | sticky;
      e      = {2'b00, x[30:23]};
      done   = 1'b0;
      if (x[31] == y[31]) begin
        s = {1'b0, mx} + {1'b0, mys};
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 10'sd1;
        end
      end else begin
        s = {1'b0, mx - mys};
        for (int i = 0; i < 27; i++) begin
          if (!done) begin
            if (s[26]) begin
              done = 1'b1;
            end else begin
              s = s << 1;
              e = e - 10'sd1;
            end
          end
        end
      end
      // Round to nearest even on guard/round/sticky
      rnd = s[2] & (s[1] | s[0] | s[3]);
      m   = {1'b0, s[26:3]} + {24'd0, rnd};
      if (m[24]) begin
        m = m >> 1;
        e = e + 10'sd1;
      end
      if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
        r = 32'h7FC0_0000;
      end else if (x[30:23] == 8'hFF) begin
        r = ((y[30:23] == 8'hFF) && (x[31] != y[31])) ? 32'h7FC0_0000 : x;
      end else if (x[30:23] == 8'd0) begin
        r = {x[31] & y[31], 31'd0};
      end else if (s == 28'd0) begin
        r = 32'd0;
      end else if (e <= 10'sd0) begin
        r = {x[31], 31'd0};
      end else if (e >= 10'sd255) begin
        r = {x[31], 8'hFF, 23'd0};
      end else begin
        r = {x[31], e[7:0], m[22:0]};
      end
      fp_add = r;
    end
  endfunction

  logic [31:0] pipe_q [LAT];

  // Adder pipeline: compute in stage 0, then delay through the remaining stages
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
    end else if (clk_en) begin
      pipe_q[0] <= fp_add(dataa, datab);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

module pipe_addn #(
  parameter int LOG2N   = 2,
  parameter int ADD_LAT = 7
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [31:0] in,
  input  logic        flush,
  output logic [31:0] result,
  output logic        out_valid,
  output logic        full
);

  localparam int N    = 1 << LOG2N;
  localparam int VLAT = 1 + LOG2N * ADD_LAT;
  localparam int FW   = LOG2N + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(N);
  localparam logic [FW-1:0] FILL_WC  = FW'(N - 1);

  logic [31:0]     tap_q [N];
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_d;
  logic [VLAT-1:0] vp_q;
  logic [31:0]     result_q;
  logic [31:0]     result_d;
  logic            out_valid_q;
  logic            accept;
  logic            wc;
  // Heap-ordered tree: node 0 is the root, nodes N-1..2N-2 are the taps
  logic [31:0]     node [2*N-1];

`ifdef PIPE_ADDN_MEAN_EN
  function automatic logic [31:0] div_n(input logic [31:0] s);
    logic [7:0] e;
    begin
      e = s[30:23];
      if (e == 8'hFF) begin
        div_n = s;
      end else if (e <= 8'(LOG2N)) begin
        div_n = {s[31], 31'd0};
      end else begin
        div_n = {s[31], e - 8'(LOG2N), s[22:0]};
      end
    end
  endfunction
`endif

  // flush beats a same-cycle sample
  assign accept = clk_en & in_valid & ~flush;
  assign wc     = accept & (fill_q >= FILL_WC);

  // Next fill count: cleared by flush, saturating increment on accept
  always_comb begin
    fill_d = fill_q;
    if (clk_en && flush) begin
      fill_d = '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + FW'(1);
    end else begin
      fill_d = fill_q;
    end
  end

  // Output register input: root of the tree, optionally scaled by 1/N
  always_comb begin
`ifdef PIPE_ADDN_MEAN_EN
    result_d = div_n(node[0]);
`else
    result_d = node[0];
`endif
  end

  // Fill counter
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      fill_q <= '0;
    end else if (clk_en) begin
      fill_q <= fill_d;
    end
  end

  // Tap chain: shift on accept, clear on flush
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < N; k++) tap_q[k] <= 32'd0;
    end else if (clk_en) begin
      if (flush) begin
        for (int k = 0; k < N; k++) tap_q[k] <= 32'd0;
      end else if (accept) begin
        tap_q[0] <= in;
        for (int k = 1; k < N; k++) tap_q[k] <= tap_q[k-1];
      end
    end
  end

  // Valid pipe tracks window-complete through the tree, in lock step with it
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      vp_q <= '0;
    end else if (clk_en) begin
      vp_q <= {vp_q[VLAT-2:0], wc};
    end
  end

  // Output register; out_valid only changes on enabled cycles so a pulse is never lost
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else if (clk_en) begin
      if (vp_q[VLAT-1]) result_q <= result_d;
      out_valid_q <= vp_q[VLAT-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign node[N-1+k] = tap_q[k];
  end

  for (genvar j = 0; j < N - 1; j++) begin : g_add
    float_add #(.LAT(ADD_LAT)) u_add (
      .clock  (clock),
      .aclr   (~aclr_n),
      .clk_en (clk_en),
      .dataa  (node[2*j+1]),
      .datab  (node[2*j+2]),
      .result (node[j])
    );
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign full      = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_pipe_addn.sv
// Directed bench for pipe_addn at default parameters (N=4, ADD_LAT=7).
// A negedge monitor logs accept cycles and out_valid pulses; each test then
// checks result values and accept-to-output cycle distances.
module tb_pipe_addn;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        clk_en;
  logic        in_valid;
  logic [31:0] in;
  logic        flush;
  logic [31:0] result;
  logic        out_valid;
  logic        full;

  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;
  localparam logic [31:0] F9 = 32'h4110_0000;
`ifdef PIPE_ADDN_MEAN_EN
  localparam logic [31:0] E10 = 32'h4020_0000;
  localparam logic [31:0] E14 = 32'h4060_0000;
  localparam logic [31:0] E4  = 32'h3F80_0000;
`else
  localparam logic [31:0] E10 = 32'h4120_0000;
  localparam logic [31:0] E14 = 32'h4160_0000;
  localparam logic [31:0] E4  = 32'h4080_0000;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int          out_cyc [$];
  logic [31:0] out_val [$];
  int          acc_cyc [$];

  pipe_addn dut (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in        (in),
    .flush     (flush),
    .result    (result),
    .out_valid (out_valid),
    .full      (full)
  );

  always #5 clock = ~clock;

  // Mid-cycle monitor: a pulse counts only on an enabled cycle
  always @(negedge clock) begin
    if (clk_en && out_valid) begin
      out_cyc.push_back(cyc);
      out_val.push_back(result);
    end
    if (aclr_n && clk_en && in_valid && !flush) acc_cyc.push_back(cyc);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic ce, input logic fl);
    in_valid = v;
    in       = x;
    clk_en   = ce;
    flush    = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [31:0] x);
    drive(1'b1, x, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic clear_logs();
    out_cyc.delete();
    out_val.delete();
    acc_cyc.delete();
  endtask

  task automatic pulse_reset();
    aclr_n = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    aclr_n = 1'b1;
    idle(2);
    clear_logs();
  endtask

  initial begin
    aclr_n   = 1'b0;
    clk_en   = 1'b1;
    in_valid = 1'b0;
    in       = 32'd0;
    flush    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    aclr_n = 1'b1;
    idle(2);
    clear_logs();

    // Test 1: back-to-back stream
    feed(F1); feed(F2); feed(F3);
    check_eq("t1_notfull", {31'd0, full}, 32'd0);
    feed(F4);
    check_eq("t1_full", {31'd0, full}, 32'd1);
    feed(F5);
    idle(25);
    check_eq("t1_count", out_cyc.size(), 32'd2);
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 5) begin
      check_eq("t1_val0", out_val[0], E10);
      check_eq("t1_val1", out_val[1], E14);
      check_eq("t1_lat0", out_cyc[0] - acc_cyc[3], 32'd16);
      check_eq("t1_lat1", out_cyc[1] - acc_cyc[4], 32'd16);
    end

    // Test 2: bubbles between 4.0 and 5.0
    pulse_reset();
    feed(F1); feed(F2); feed(F3); feed(F4);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_eq("t2_full_bubble", {31'd0, full}, 32'd1);
    end
    feed(F5);
    check_eq("t2_full_end", {31'd0, full}, 32'd1);
    idle(25);
    check_eq("t2_count", out_cyc.size(), 32'd2);
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 5) begin
      check_eq("t2_val0", out_val[0], E10);
      check_eq("t2_val1", out_val[1], E14);
      check_eq("t2_lat0", out_cyc[0] - acc_cyc[3], 32'd16);
      check_eq("t2_gap", out_cyc[1] - out_cyc[0], 32'd4);
    end

    // Test 3: five stalled cycles mid-flight
    pulse_reset();
    feed(F1); feed(F2); feed(F3); feed(F4); feed(F5);
    idle(3);
    repeat (5) drive(1'b0, 32'd0, 1'b0, 1'b0);
    idle(25);
    check_eq("t3_count", out_cyc.size(), 32'd2);
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 5) begin
      check_eq("t3_val0", out_val[0], E10);
      check_eq("t3_val1", out_val[1], E14);
      check_eq("t3_lat0", out_cyc[0] - acc_cyc[3], 32'd21);
      check_eq("t3_lat1", out_cyc[1] - acc_cyc[4], 32'd21);
    end

    // Test 4: flush (with a competing sample) after 4.0, then 1.0 x4
    pulse_reset();
    feed(F1); feed(F2); feed(F3); feed(F4);
    drive(1'b1, F9, 1'b1, 1'b1);
    check_eq("t4_full_flush", {31'd0, full}, 32'd0);
    feed(F1); feed(F1); feed(F1);
    check_eq("t4_notfull", {31'd0, full}, 32'd0);
    feed(F1);
    check_eq("t4_refull", {31'd0, full}, 32'd1);
    idle(25);
    check_eq("t4_count", out_cyc.size(), 32'd2);
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 8) begin
      check_eq("t4_val0", out_val[0], E10);
      check_eq("t4_val1", out_val[1], E4);
      check_eq("t4_lat0", out_cyc[0] - acc_cyc[3], 32'd16);
      check_eq("t4_lat1", out_cyc[1] - acc_cyc[7], 32'd16);
    end

    // Test 5: async reset with three results still in flight
    pulse_reset();
    feed(F1); feed(F2); feed(F3); feed(F4); feed(F5); feed(F6); feed(F7);
    idle(12);
    check_eq("t5_pre_val", result, E10);
    check_eq("t5_pre_ovalid", {31'd0, out_valid}, 32'd1);
    aclr_n = 1'b0;
    #2;
    check_eq("t5_rst_result", result, 32'd0);
    check_eq("t5_rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("t5_rst_full", {31'd0, full}, 32'd0);
    @(posedge clock);
    #1;
    aclr_n = 1'b1;
    clear_logs();
    idle(2);
    feed(F1); feed(F1); feed(F1); feed(F1);
    idle(25);
    check_eq("t5_count", out_cyc.size(), 32'd1);
    if (out_cyc.size() >= 1 && acc_cyc.size() >= 4) begin
      check_eq("t5_val", out_val[0], E4);
      check_eq("t5_lat", out_cyc[0] - acc_cyc[3], 32'd16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
